// File: rtl/divider.sv
// divider: unsigned sequential restoring divider, one quotient bit per clock.
// Result is {remainder, quotient}; a zero divisor yields {dividend, all ones} with div_zero set.
module divider #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Divu,
   input  logic [WIDTH-1:0]   dataA,
   input  logic [WIDTH-1:0]   dataB,
   output logic [2*WIDTH-1:0] dataOut,
   output logic               busy,
   output logic               done,
   output logic               div_zero
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state;
   logic [WIDTH-1:0] d, q, q_next;
   logic [WIDTH:0]   r, t, r_next;
   logic [CW-1:0]    count;
   logic             zflag, ge;
   // With d == 0 every step subtracts nothing, so r ends as the dividend and q as all ones.
   always_comb begin
      t      = {r[WIDTH-1:0], q[WIDTH-1]};
      ge     = t >= {1'b0, d};
      r_next = ge ? t - {1'b0, d} : t;
      q_next = {q[WIDTH-2:0], ge};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         d        <= '0;
         q        <= '0;
         r        <= '0;
         count    <= '0;
         zflag    <= 1'b0;
         dataOut  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            busy <= Divu;
            if (Divu) begin
               state <= RUN;
               d     <= dataB;
               q     <= dataA;
               r     <= '0;
               count <= '0;
               zflag <= dataB == '0;
            end
         end else begin
            r     <= r_next;
            q     <= q_next;
            count <= count + 1'b1;
            if (count == LAST) begin
               state    <= IDLE;
               done     <= 1'b1;
               dataOut  <= {r_next[WIDTH-1:0], q_next};
               div_zero <= zflag;
            end
         end
      end
   end
endmodule

// File: tb/tb_divider.sv
// tb_divider: randomized and directed checks of divider against a plain-arithmetic model.
module tb_divider;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        Divu = 1'b0;
   logic [31:0] dataA = '0;
   logic [31:0] dataB = '0;
   logic [63:0] dataOut;
   logic        busy, done, div_zero;
   int          n_cmp = 0;
   int          n_bad = 0;

   divider #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .Divu(Divu), .dataA(dataA), .dataB(dataB),
      .dataOut(dataOut), .busy(busy), .done(done), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
      return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch a division and wait for done; lat counts clocks from the start edge.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output logic z, output int lat);
      Divu = 1'b1; dataA = a; dataB = b;
      tick();
      Divu = 1'b0; dataA = $urandom; dataB = $urandom;
      lat = 1;
      while (!done && lat < 40) begin
         tick();
         if (!done) lat++;
      end
      if (!done) lat = 99;
      res = dataOut;
      z = div_zero;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      Divu = 1'b1; dataA = 32'd50; dataB = 32'd5;
      tick(); tick();
      Divu = 1'b0;
      reset = 1'b0;
      n_cmp += 4;
      if (dataOut !== 64'd0) begin n_bad++; $display("FAIL reset_dataOut got=%h exp=0", dataOut); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
      if (div_zero !== 1'b0) begin n_bad++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
      tick();
   endtask

   task automatic test_directed();
      logic [31:0] as [4] = '{32'd100, 32'hFFFF_FFFF, 32'd3, 32'd5};
      logic [31:0] bs [4] = '{32'd7, 32'd1, 32'd10, 32'd0};
      logic [63:0] res;
      logic        z;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         do_div(as[i], bs[i], res, z, lat);
         n_cmp += 3;
         if (res !== model(as[i], bs[i])) begin n_bad++; $display("FAIL dir%0d_data got=%h exp=%h", i, res, model(as[i], bs[i])); end
         if (z !== (bs[i] == 0)) begin n_bad++; $display("FAIL dir%0d_zero got=%b exp=%b", i, z, bs[i] == 0); end
         if (lat !== 32) begin n_bad++; $display("FAIL dir%0d_latency got=%0d exp=32", i, lat); end
         tick();
         n_cmp += 2;
         if (done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, done); end
         if (busy !== 1'b0) begin n_bad++; $display("FAIL dir%0d_busy_drop got=%b exp=0", i, busy); end
      end
      n_cmp++;
      if (model(32'd100, 32'd7) !== 64'h00000002_0000000E) begin n_bad++; $display("FAIL model_100_7 got=%h exp=%h", model(32'd100, 32'd7), 64'h00000002_0000000E); end
   endtask

   task automatic test_ignore_busy();
      int lat = 1;
      Divu = 1'b1; dataA = 32'd100; dataB = 32'd7;
      tick();
      Divu = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL ign_busy got=%b exp=1", busy); end
      while (!done && lat < 40) begin
         if (lat == 10) begin Divu = 1'b1; dataA = 32'd9; dataB = 32'd3; end
         if (lat == 11) Divu = 1'b0;
         tick();
         if (!done) lat++;
      end
      n_cmp += 2;
      if (dataOut !== 64'h00000002_0000000E) begin n_bad++; $display("FAIL ign_data got=%h exp=%h", dataOut, 64'h00000002_0000000E); end
      if (lat !== 32) begin n_bad++; $display("FAIL ign_latency got=%0d exp=32", lat); end
      tick();
   endtask

   task automatic test_reset_abort();
      int seen = 0;
      Divu = 1'b1; dataA = 32'd1000; dataB = 32'd3;
      tick();
      Divu = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp += 2;
      if (dataOut !== 64'd0) begin n_bad++; $display("FAIL abort_dataOut got=%h exp=0", dataOut); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] res;
      logic        z;
      int          lat;
      int          extra = 0;
      do_div(32'd100, 32'd7, res, z, lat);
      n_cmp++;
      if (res !== 64'h00000002_0000000E) begin n_bad++; $display("FAIL b2b_first got=%h exp=%h", res, 64'h00000002_0000000E); end
      Divu = 1'b1; dataA = 32'd81; dataB = 32'd9;
      lat = 0;
      do begin
         tick();
         Divu = 1'b0;
         lat++;
         if (lat == 1 && !busy) extra++;
      end while (!done && lat < 40);
      n_cmp += 3;
      if (dataOut !== 64'h00000000_00000009) begin n_bad++; $display("FAIL b2b_second got=%h exp=%h", dataOut, 64'h00000000_00000009); end
      if (lat !== 33) begin n_bad++; $display("FAIL b2b_period got=%0d exp=33", lat); end
      if (extra !== 0) begin n_bad++; $display("FAIL b2b_busy_held got=%0d exp=0", extra); end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic [63:0] res;
      logic        z;
      int          lat;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = $urandom_range(1, 16);
            2: b = a;
            3: b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         do_div(a, b, res, z, lat);
         n_cmp += 3;
         if (res !== model(a, b)) begin n_bad++; $display("FAIL rnd%0d_data a=%h b=%h got=%h exp=%h", i, a, b, res, model(a, b)); end
         if (z !== (b == 0)) begin n_bad++; $display("FAIL rnd%0d_zero got=%b exp=%b", i, z, b == 0); end
         if (lat !== 32) begin n_bad++; $display("FAIL rnd%0d_latency got=%0d exp=32", i, lat); end
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_busy();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
